clownfish_mem_arbiter: RTL and testbench

- Registered two-port arbiter between the L1 I-cache and L1 D-cache refill/writeback ports and the single external 512-bit line memory port of the no-L2 SoC.
- Grants on D-cache priority, with a starvation guard for the I-cache.
- Keeps one transaction outstanding, buffers the request, and routes the response only to the owner.
- Applies 32-to-36-bit PAE extension per requester and raises a timeout error if memory never responds.

---
 rtl/clownfish_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_clownfish_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clownfish_mem_arbiter.sv
// Line-memory arbiter between the L1 I-cache and D-cache with D priority,
// an I-cache starvation guard, PAE address extension and a response timeout.
module clownfish_mem_arbiter #(
  parameter int VA_W           = 32,
  parameter int PA_W           = 36,
  parameter int LINE_W         = 512,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req_valid_i,
  input  logic [VA_W-1:0]      i_req_addr_i,
  output logic                 i_req_ready_o,
  output logic                 i_resp_valid_o,
  output logic [LINE_W-1:0]    i_resp_data_o,
  output logic                 i_resp_error_o,
  input  logic                 i_resp_ready_i,
  input  logic                 d_req_valid_i,
  input  logic [VA_W-1:0]      d_req_addr_i,
  input  logic                 d_req_we_i,
  input  logic [LINE_W-1:0]    d_req_data_i,
  output logic                 d_req_ready_o,
  output logic                 d_resp_valid_o,
  output logic [LINE_W-1:0]    d_resp_data_o,
  output logic                 d_resp_error_o,
  input  logic                 d_resp_ready_i,
  input  logic [PA_W-VA_W-1:0] i_pae_hi_i,
  input  logic [PA_W-VA_W-1:0] d_pae_hi_i,
  output logic                 mem_req_valid_o,
  output logic [PA_W-1:0]      mem_req_addr_o,
  output logic                 mem_req_we_o,
  output logic [LINE_W-1:0]    mem_req_data_o,
  input  logic                 mem_req_ready_i,
  input  logic                 mem_resp_valid_i,
  input  logic [LINE_W-1:0]    mem_resp_data_i,
  input  logic                 mem_resp_error_i,
  output logic                 mem_resp_ready_o,
  output logic                 timeout_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, RESP, TOERR} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;  // 1: D-cache owns the transaction
  logic [PA_W-1:0]   addr_q, addr_d;
  logic              we_q, we_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic              req_valid_q, req_valid_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              to_first_q, to_first_d;
  logic              grant_i, grant_d, owner_rdy;

  assign owner_rdy = owner_q ? d_resp_ready_i : i_resp_ready_i;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (starve_q >= SW'(STARVE_LIMIT) && i_req_valid_i) grant_i = 1'b1;
      else if (d_req_valid_i)                              grant_d = 1'b1;
      else if (i_req_valid_i)                              grant_i = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    data_d     = data_q;
    starve_d   = starve_q;
    to_cnt_d   = to_cnt_q;
    to_first_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          owner_d = 1'b1;
          addr_d  = {d_pae_hi_i, d_req_addr_i};
          we_d    = d_req_we_i;
          data_d  = d_req_data_i;
          state_d = REQ;
          if (i_req_valid_i && starve_q < SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
        end else if (grant_i) begin
          owner_d  = 1'b0;
          addr_d   = {i_pae_hi_i, i_req_addr_i};
          we_d     = 1'b0;
          data_d   = '0;
          starve_d = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready_i) begin
          state_d  = RESP;
          to_cnt_d = '0;
        end
      end
      RESP: begin
        if (mem_resp_valid_i && owner_rdy) begin
          state_d = IDLE;
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d    = TOERR;
          to_first_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      TOERR: begin
        if (owner_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_valid_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      data_q      <= '0;
      req_valid_q <= 1'b0;
      starve_q    <= '0;
      to_cnt_q    <= '0;
      to_first_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      data_q      <= data_d;
      req_valid_q <= req_valid_d;
      starve_q    <= starve_d;
      to_cnt_q    <= to_cnt_d;
      to_first_q  <= to_first_d;
    end
  end

  // Request fields are gated so stale buffer contents never show outside REQ.
  assign mem_req_valid_o = req_valid_q;
  assign mem_req_addr_o  = req_valid_q ? addr_q : '0;
  assign mem_req_we_o    = req_valid_q & we_q;
  assign mem_req_data_o  = req_valid_q ? data_q : '0;
  assign i_req_ready_o   = grant_i;
  assign d_req_ready_o   = grant_d;
  assign timeout_o       = to_first_q;

  always_comb begin
    i_resp_valid_o   = 1'b0;
    i_resp_data_o    = '0;
    i_resp_error_o   = 1'b0;
    d_resp_valid_o   = 1'b0;
    d_resp_data_o    = '0;
    d_resp_error_o   = 1'b0;
    mem_resp_ready_o = 1'b1;
    case (state_q)
      REQ: mem_resp_ready_o = 1'b0;
      RESP: begin
        mem_resp_ready_o = owner_rdy;
        if (owner_q) begin
          d_resp_valid_o = mem_resp_valid_i;
          d_resp_data_o  = mem_resp_data_i;
          d_resp_error_o = mem_resp_error_i;
        end else begin
          i_resp_valid_o = mem_resp_valid_i;
          i_resp_data_o  = mem_resp_data_i;
          i_resp_error_o = mem_resp_error_i;
        end
      end
      TOERR: begin
        if (owner_q) begin
          d_resp_valid_o = 1'b1;
          d_resp_error_o = 1'b1;
        end else begin
          i_resp_valid_o = 1'b1;
          i_resp_error_o = 1'b1;
        end
      end
      default: mem_resp_ready_o = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_clownfish_mem_arbiter.sv
// Randomized transaction-level bench for clownfish_mem_arbiter.
module tb_clownfish_mem_arbiter;
  localparam int VA_W = 32, PA_W = 36, LINE_W = 512;
  localparam int STARVE_LIMIT = 4, TIMEOUT_CYCLES = 1024;

  logic clk = 1'b0;
  logic rst;
  logic i_req_valid_i, i_req_ready_o, i_resp_valid_o, i_resp_error_o, i_resp_ready_i;
  logic [VA_W-1:0] i_req_addr_i, d_req_addr_i;
  logic [LINE_W-1:0] i_resp_data_o, d_resp_data_o, d_req_data_i, mem_req_data_o, mem_resp_data_i;
  logic d_req_valid_i, d_req_we_i, d_req_ready_o, d_resp_valid_o, d_resp_error_o, d_resp_ready_i;
  logic [PA_W-VA_W-1:0] i_pae_hi_i, d_pae_hi_i;
  logic mem_req_valid_o, mem_req_we_o, mem_req_ready_i;
  logic [PA_W-1:0] mem_req_addr_o;
  logic mem_resp_valid_i, mem_resp_error_i, mem_resp_ready_o, timeout_o;

  clownfish_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req_valid_i(i_req_valid_i), .i_req_addr_i(i_req_addr_i), .i_req_ready_o(i_req_ready_o),
    .i_resp_valid_o(i_resp_valid_o), .i_resp_data_o(i_resp_data_o), .i_resp_error_o(i_resp_error_o),
    .i_resp_ready_i(i_resp_ready_i),
    .d_req_valid_i(d_req_valid_i), .d_req_addr_i(d_req_addr_i), .d_req_we_i(d_req_we_i),
    .d_req_data_i(d_req_data_i), .d_req_ready_o(d_req_ready_o),
    .d_resp_valid_o(d_resp_valid_o), .d_resp_data_o(d_resp_data_o), .d_resp_error_o(d_resp_error_o),
    .d_resp_ready_i(d_resp_ready_i),
    .i_pae_hi_i(i_pae_hi_i), .d_pae_hi_i(d_pae_hi_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o), .mem_req_we_o(mem_req_we_o),
    .mem_req_data_o(mem_req_data_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
    .mem_resp_error_i(mem_resp_error_i), .mem_resp_ready_o(mem_resp_ready_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int starve_m = 0;  // model: consecutive I-cache losses

  task automatic chk(input string tag, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic quiet_inputs();
    i_req_valid_i = 0; i_req_addr_i = '0; i_resp_ready_i = 0; i_pae_hi_i = '0;
    d_req_valid_i = 0; d_req_addr_i = '0; d_req_we_i = 0; d_req_data_i = '0;
    d_resp_ready_i = 0; d_pae_hi_i = '0;
    mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_data_i = '0; mem_resp_error_i = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mrv"}, mem_req_valid_o, 0);
    chk({tag, "_maddr"}, mem_req_addr_o, 0);
    chk({tag, "_mwe"}, mem_req_we_o, 0);
    chk({tag, "_mdata"}, mem_req_data_o, 0);
    chk({tag, "_mrr"}, mem_resp_ready_o, 1);
    chk({tag, "_rdy"}, {i_req_ready_o, d_req_ready_o}, 0);
    chk({tag, "_rv"}, {i_resp_valid_o, d_resp_valid_o, i_resp_error_o, d_resp_error_o}, 0);
    chk({tag, "_rd"}, i_resp_data_o | d_resp_data_o, 0);
    chk({tag, "_tmo"}, timeout_o, 0);
  endtask

  // One whole transaction starting in IDLE; returns the grant the DUT showed.
  task automatic txn(input bit iv, input bit dv, input bit dwe, input int req_wait,
                     input int resp_lat, input int stall, input bit tmo, output bit obs_d);
    logic [VA_W-1:0] ia, da;
    logic [PA_W-VA_W-1:0] ip, dp;
    logic [LINE_W-1:0] wd, rd;
    logic re;
    bit win_d;
    logic [PA_W-1:0] ea;
    ia = $urandom; da = $urandom; ip = $urandom; dp = $urandom;
    wd = rand_line(); rd = rand_line(); re = 1'($urandom);
    win_d = (starve_m >= STARVE_LIMIT && iv) ? 1'b0 : dv;
    ea = win_d ? {dp, da} : {ip, ia};

    i_req_valid_i = iv; i_req_addr_i = ia; i_pae_hi_i = ip;
    d_req_valid_i = dv; d_req_addr_i = da; d_pae_hi_i = dp; d_req_we_i = dwe; d_req_data_i = wd;
    #1;
    obs_d = d_req_ready_o;
    chk("grant_i", i_req_ready_o, !win_d);
    chk("grant_d", d_req_ready_o, win_d);
    chk("grant_mrv", mem_req_valid_o, 0);
    if (win_d && iv) starve_m = (starve_m < STARVE_LIMIT) ? starve_m + 1 : starve_m;
    else if (!win_d) starve_m = 0;
    tick();

    for (int k = 0; k <= req_wait; k++) begin
      i_req_valid_i = 1'($urandom); d_req_valid_i = 1'($urandom);
      i_req_addr_i = $urandom; d_req_addr_i = $urandom; d_req_data_i = rand_line();
      i_pae_hi_i = $urandom; d_pae_hi_i = $urandom; d_req_we_i = 1'($urandom);
      mem_req_ready_i = (k == req_wait);
      #1;
      chk("req_mrv", mem_req_valid_o, 1);
      chk("req_addr", mem_req_addr_o, ea);
      chk("req_we", mem_req_we_o, win_d ? dwe : 1'b0);
      chk("req_data", mem_req_data_o, win_d ? wd : '0);
      chk("req_rdy", {i_req_ready_o, d_req_ready_o}, 0);
      chk("req_mrr", mem_resp_ready_o, 0);
      tick();
    end
    mem_req_ready_i = 0; i_req_valid_i = 0; d_req_valid_i = 0;

    if (tmo) begin
      for (int k = 0; k < TIMEOUT_CYCLES; k++) begin
        i_resp_ready_i = 1'($urandom); d_resp_ready_i = 1'($urandom);
        #1;
        chk("tw_v", {i_resp_valid_o, d_resp_valid_o}, 0);
        chk("tw_tmo", timeout_o, 0);
        tick();
      end
      for (int k = 0; k < 2; k++) begin
        if (win_d) begin d_resp_ready_i = (k == 1); i_resp_ready_i = 1'($urandom); end
        else begin i_resp_ready_i = (k == 1); d_resp_ready_i = 1'($urandom); end
        mem_resp_valid_i = 1'($urandom); mem_resp_data_i = rand_line();
        #1;
        chk("to_own_v", win_d ? d_resp_valid_o : i_resp_valid_o, 1);
        chk("to_own_e", win_d ? d_resp_error_o : i_resp_error_o, 1);
        chk("to_own_d", win_d ? d_resp_data_o : i_resp_data_o, 0);
        chk("to_oth_v", win_d ? i_resp_valid_o : d_resp_valid_o, 0);
        chk("to_pulse", timeout_o, k == 0);
        chk("to_mrr", mem_resp_ready_o, 1);
        tick();
      end
      quiet_inputs();
      mem_resp_valid_i = 1; mem_resp_data_i = rand_line(); mem_resp_error_i = 1;
      i_resp_ready_i = 1; d_resp_ready_i = 1;
      #1;
      chk("late_v", {i_resp_valid_o, d_resp_valid_o}, 0);
      chk("late_mrr", mem_resp_ready_o, 1);
      chk("late_tmo", timeout_o, 0);
      tick();
    end else begin
      for (int k = 0; k < resp_lat; k++) begin
        i_resp_ready_i = 1'($urandom); d_resp_ready_i = 1'($urandom);
        #1;
        chk("lat_v", {i_resp_valid_o, d_resp_valid_o}, 0);
        tick();
      end
      for (int k = 0; k <= stall; k++) begin
        mem_resp_valid_i = 1; mem_resp_data_i = rd; mem_resp_error_i = re;
        if (win_d) begin d_resp_ready_i = (k == stall); i_resp_ready_i = 1'($urandom); end
        else begin i_resp_ready_i = (k == stall); d_resp_ready_i = 1'($urandom); end
        #1;
        chk("own_v", win_d ? d_resp_valid_o : i_resp_valid_o, 1);
        chk("oth_v", win_d ? i_resp_valid_o : d_resp_valid_o, 0);
        chk("own_d", win_d ? d_resp_data_o : i_resp_data_o, rd);
        chk("own_e", win_d ? d_resp_error_o : i_resp_error_o, re);
        chk("resp_mrr", mem_resp_ready_o, k == stall);
        tick();
      end
    end
    quiet_inputs();
  endtask

  // Reset while a transaction sits in REQ (where=0) or RESP (where=1).
  task automatic reset_mid(input int where);
    bit od;
    quiet_inputs();
    d_req_valid_i = 1; d_req_addr_i = $urandom; d_pae_hi_i = $urandom;
    tick();
    d_req_valid_i = 0;
    if (where == 1) begin mem_req_ready_i = 1; tick(); mem_req_ready_i = 0; end
    rst = 1;
    tick();
    rst = 0;
    #1;
    check_idle_outputs(where == 0 ? "rst_req" : "rst_resp");
    starve_m = 0;
    tick();
    txn(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, od);
    chk("post_rst_grant", od, 1);
  endtask

  bit exp_pat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    bit od;
    bit iv, dv;
    quiet_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    check_idle_outputs("reset");
    tick();

    txn(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, od);
    chk("i_single", od, 0);
    txn(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, od);
    chk("d_single", od, 1);

    starve_m = 0;
    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 10; n++) begin
      txn(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, od);
      chk("grant_pat", od, exp_pat[n]);
    end

    txn(1'b0, 1'b1, 1'b1, 5, 0, 0, 1'b0, od);
    txn(1'b1, 1'b0, 1'b0, 0, 1, 3, 1'b0, od);
    txn(1'b0, 1'b1, 1'b0, 0, 0, 3, 1'b0, od);

    txn(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1, od);
    txn(1'b0, 1'b1, 1'b1, 1, 0, 0, 1'b1, od);

    reset_mid(0);
    reset_mid(1);

    for (int n = 0; n < 150; n++) begin
      iv = 1'($urandom); dv = 1'($urandom);
      if (!iv && !dv) begin
        mem_resp_valid_i = 1'($urandom); mem_resp_data_i = rand_line();
        i_resp_ready_i = 1'($urandom); d_resp_ready_i = 1'($urandom);
        #1;
        check_idle_outputs("idle");
        tick();
        quiet_inputs();
      end else begin
        txn(iv, dv, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 2)), 1'b0, od);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
